timer_counter: RTL and testbench

//  Memory-mapped countdown timer on the data-memory side of the store path. It consumes
//  the per-byte strobes, aligned write data and address from the store byte-enable stage.
//  It asserts an interrupt request toward CP0 when a count expires.
//  The system bridge instantiates two copies, TC0 at 0x7F00 and TC1 at 0x7F10.

---
 rtl/timer_counter.sv | 132 +++++++++++++
 tb/tb_timer_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer. Decodes BASE..BASE+0xB on the store path and
// raises a level interrupt toward CP0 when a count expires.
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  // CTRL layout: [0] EN, [2:1] MODE, [3] IM
  logic [3:0]                  ctrl_q, ctrl_d;
  logic [NUM_LANES-1:0][7:0]   preset_q, preset_d;
  logic [31:0]                 count_q, count_d;
  logic                        flag_q, flag_d;
  state_e                      state_q, state_d;

  logic                        hit;
  logic                        wr;
  logic [1:0]                  off;
  logic                        ctrl_wr;
  logic                        preset_wr;
  logic                        fsm_flag;
  logic                        fsm_en_clr;
  logic [NUM_LANES-1:0][7:0]   wlane;
  logic                        unused_addr;

  assign hit         = (addr[31:4] == BASE[31:4]);
  assign off         = addr[3:2];
  assign wr          = hit && (byteen != 4'b0000);
  assign ctrl_wr     = wr && (off == 2'd0) && byteen[0];
  assign preset_wr   = wr && (off == 2'd1);
  assign wlane       = wdata;
  assign unused_addr = ^addr[1:0];

  // Byte-lane merge into PRESET: only strobed lanes take new data
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign preset_d[i] = (preset_wr && byteen[i]) ? wlane[i] : preset_q[i];
  end

  // Countdown FSM: next state, next COUNT and the flag/EN effects of expiry
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fsm_flag   = flag_q;
    fsm_en_clr = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_q[0]) state_d = S_LOAD;
      S_LOAD: begin
        // Uses the PRESET held before this edge, even if it is written now
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 0 expires like 1, so PRESET=0 acts as PRESET=1
          count_d  = 32'd0;
          fsm_flag = 1'b1;
          state_d  = S_INT;
        end
      end
      S_INT: begin
        // Auto-reload drops the flag after one cycle; other modes stop the timer
        if (ctrl_q[2:1] == 2'b01) fsm_flag   = 1'b0;
        else                      fsm_en_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CTRL/flag next state: a software CTRL write overrides the FSM's EN clear
  always_comb begin
    ctrl_d = ctrl_q;
    flag_d = fsm_flag;
    if (fsm_en_clr) ctrl_d[0] = 1'b0;
    if (ctrl_wr) begin
      ctrl_d = wdata[3:0];
      flag_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
    end
  end

  // Read mux: pure function of addr and current register values
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed vector table, multi-cycle timing
// sequences, and randomized traffic checked against a behavioural model.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  timer_counter #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  logic        m_en = 1'b0, m_im = 1'b0, m_flag = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [31:0] m_preset = 32'd0, m_count = 32'd0;
  int          m_phase = 0; // 0 idle, 1 load, 2 counting, 3 expired

  task automatic model_step();
    logic [31:0] old_preset;
    bit          hit;
    if (reset) begin
      m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
      m_preset = 0; m_count = 0; m_phase = 0;
      return;
    end
    hit = (addr[31:4] == BASE[31:4]) && (byteen != 4'd0);
    old_preset = m_preset;
    case (m_phase)
      0: if (m_en) m_phase = 1;
      1: begin m_count = old_preset; m_phase = 2; end
      2: begin
        if (!m_en) m_phase = 0;
        else if (m_count > 1) m_count = m_count - 1;
        else begin m_count = 0; m_flag = 1; m_phase = 3; end
      end
      default: begin
        if (m_mode == 2'b01) m_flag = 0;
        else m_en = 0;
        m_phase = 0;
      end
    endcase
    if (hit && addr[3:2] == 2'd0 && byteen[0]) begin
      {m_im, m_mode, m_en} = wdata[3:0];
      m_flag = 0;
    end
    if (hit && addr[3:2] == 2'd1)
      for (int i = 0; i < 4; i++)
        if (byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) model_step();

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs sampled 1ns later
  task automatic step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    reset = 1'b0;
    addr = a; byteen = be; wdata = d;
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    step(a, 4'd0, 32'd0);
    chk(nm, rdata, exp);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    bit found;
    int errs;
    int hi;
    logic [31:0] cnt_s [31];
    logic        irq_s [31];

    vecs[0]  = '{BASE + 32'h4,  4'b1111, 32'hAABB_CCDD, BASE + 32'h4,  32'hAABB_CCDD};
    vecs[1]  = '{BASE + 32'h4,  4'b0100, 32'h0011_0000, BASE + 32'h4,  32'hAA11_CCDD};
    vecs[2]  = '{BASE + 32'h8,  4'b1111, 32'hFFFF_FFFF, BASE + 32'h8,  32'h0};
    vecs[3]  = '{BASE + 32'hC,  4'b1111, 32'h1234_5678, BASE + 32'hC,  32'h0};
    vecs[4]  = '{BASE + 32'h10, 4'b1111, 32'hFFFF_FFFF, BASE + 32'h4,  32'hAA11_CCDD};
    vecs[5]  = '{BASE + 32'h14, 4'b1111, 32'hFFFF_FFFF, BASE + 32'h14, 32'h0};
    vecs[6]  = '{BASE,          4'b1110, 32'hFFFF_FFFF, BASE,          32'h0};
    vecs[7]  = '{BASE,          4'b0001, 32'hFFFF_FFF6, BASE,          32'h6};
    vecs[8]  = '{BASE,          4'b0001, 32'h0,         BASE,          32'h0};
    vecs[9]  = '{BASE + 32'h4,  4'b1001, 32'h01FF_FF02, BASE + 32'h4,  32'h0111_CC02};
    vecs[10] = '{BASE + 32'h7,  4'b0010, 32'h0000_EE00, BASE + 32'h5,  32'h0111_EE02};

    repeat (2) @(negedge clk);

    // Reset state
    rd_chk("rst_ctrl",   BASE,          32'd0);
    rd_chk("rst_preset", BASE + 32'h4,  32'd0);
    rd_chk("rst_count",  BASE + 32'h8,  32'd0);
    rd_chk("rst_none",   BASE + 32'hC,  32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Register map and byte merge
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].be, vecs[i].d);
      rd_chk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
    end

    // One-shot: irq 7 cycles after CTRL write edge
    step(BASE + 32'h4, 4'hF, 32'd5);
    step(BASE, 4'h1, 32'h9);
    n = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(BASE + 32'h8, 4'd0, 32'd0);
      if (irq) found = 1; else n++;
    end
    chk("t2_latency", n, 32'd7);
    chk("t2_count_at_irq", rdata, 32'd0);
    rd_chk("t2_ctrl_after", BASE, 32'h8);
    chk("t2_irq_level", {31'd0, irq}, 32'd1);
    step(BASE + 32'h8, 4'd0, 32'd0);
    step(BASE + 32'h8, 4'd0, 32'd0);
    chk("t2_irq_hold", {31'd0, irq}, 32'd1);
    chk("t2_count_hold", rdata, 32'd0);
    step(BASE, 4'h1, 32'h8);
    step(BASE, 4'd0, 32'd0);
    chk("t2_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload: pulse every 6 cycles, COUNT 3,2,1,0
    step(BASE + 32'h4, 4'hF, 32'd3);
    step(BASE, 4'h1, 32'hB);
    for (int s = 1; s <= 30; s++) begin
      step(BASE + 32'h8, 4'd0, 32'd0);
      cnt_s[s] = rdata;
      irq_s[s] = irq;
    end
    errs = 0;
    for (int s = 1; s <= 30; s++)
      if (irq_s[s] !== ((s % 6) == 0)) errs++;
    chk("t3_irq_pattern_errs", errs, 32'd0);
    for (int s = 3; s <= 12; s++)
      if (s <= 6 || s >= 9)
        chk($sformatf("t3_count_s%0d", s), cnt_s[s], 32'(3 - ((s - 3) % 6)));
    step(BASE, 4'h1, 32'h0);
    repeat (4) step(BASE + 32'hC, 4'd0, 32'd0);

    // Masked expiry, then CTRL write clears the hidden flag
    step(BASE + 32'h4, 4'hF, 32'd2);
    step(BASE, 4'h1, 32'h1);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      step(BASE + 32'h8, 4'd0, 32'd0);
      if (irq) hi++;
    end
    chk("t5_irq_masked", hi, 32'd0);
    rd_chk("t5_ctrl_en_cleared", BASE, 32'd0);
    step(BASE, 4'h1, 32'h8);
    step(BASE, 4'd0, 32'd0);
    chk("t5_irq_after_im", {31'd0, irq}, 32'd0);
    chk("t5_ctrl_im", rdata, 32'h8);
    step(BASE, 4'h1, 32'h0);

    // Reset mid-count at COUNT=2, then out-of-range access
    step(BASE + 32'h4, 4'hF, 32'd5);
    step(BASE, 4'h1, 32'h9);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(BASE + 32'h8, 4'd0, 32'd0);
      if (rdata == 32'd2) found = 1;
    end
    chk("t6_reached_2", {31'd0, found}, 32'd1);
    reset = 1'b1;
    rd_chk("t6_ctrl",   BASE,         32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    rd_chk("t6_preset", BASE + 32'h4, 32'd0);
    rd_chk("t6_count",  BASE + 32'h8, 32'd0);
    step(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
    step(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF);
    rd_chk("t6_oor_ctrl",   BASE,         32'd0);
    rd_chk("t6_oor_preset", BASE + 32'h4, 32'd0);
    rd_chk("t6_oor_count",  BASE + 32'h8, 32'd0);

    // Randomized traffic vs. the reference model
    for (int k = 0; k < 600; k++) begin
      int r;
      int o;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      o = $urandom_range(0, 3);
      a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h10 + 32'($urandom_range(0, 31));
      be = 4'd0;
      d  = 32'd0;
      if (r >= 2 && r < 22) begin
        be = 4'($urandom_range(1, 15));
        d  = $urandom;
        if (o == 1 && $urandom_range(0, 3) != 0) begin
          be = 4'hF;
          d  = 32'($urandom_range(0, 6));
        end
      end
      step(a, be, d);
      chk("rnd_rdata", rdata, m_read(a));
      chk("rnd_irq", {31'd0, irq}, {31'd0, m_im & m_flag});
      if (r < 2) reset = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
